// File: rtl/vga_capture_monitor.sv
// vga_capture_monitor
// Measures the timing of an incoming 12-bit VGA stream and, on request, grabs
// a rectangular window of one complete frame into an external RAM write port.
//
// Ports:
//   clk, reset_n                 pixel clock, async active-low reset
//   vga_hs/vs/de, vga_r/g/b      video input (RGB444)
//   cap_req                      capture request (level)
//   cap_busy, cap_done           capture armed/running, end-of-capture pulse
//   cap_words                    words written by the last completed capture
//   mem_we, mem_addr, mem_d      RAM write port, data = {r,g,b}
//   h_total, h_active            clocks per line, DE pixels per line
//   v_total, v_active            lines per frame, DE lines per frame
//   meas_valid                   measurements cover at least one full frame
module vga_capture_monitor #(
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int unsigned WIN_X      = 0,
  parameter int unsigned WIN_Y      = 0,
  parameter int unsigned WIN_W      = 160,
  parameter int unsigned WIN_H      = 120,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  vga_hs,
  input  logic                  vga_vs,
  input  logic                  vga_de,
  input  logic [3:0]            vga_r,
  input  logic [3:0]            vga_g,
  input  logic [3:0]            vga_b,
  input  logic                  cap_req,
  output logic                  cap_busy,
  output logic                  cap_done,
  output logic [ADDR_WIDTH:0]   cap_words,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [11:0]           mem_d,
  output logic [11:0]           h_total,
  output logic [11:0]           h_active,
  output logic [11:0]           v_total,
  output logic [11:0]           v_active,
  output logic                  meas_valid
);

  localparam int unsigned Area = WIN_W * WIN_H;
  localparam logic [ADDR_WIDTH:0] WordOne = 1;

  typedef enum logic [1:0] {StIdle, StArm, StCapt, StDone} state_e;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  // Input stage S1 and edge-detect stage S2
  logic        hs_s1_q, vs_s1_q, de_s1_q, req_s1_q, hs_s2_q, vs_s2_q;
  logic [11:0] rgb_s1_q;

  logic [11:0] hcnt_q, x_q, y_q, vcnt_q, line_total_q, line_active_q;
  logic        vs_seen_q;

  state_e              state_q;
  logic [ADDR_WIDTH:0] wr_cnt_q;

  logic        hs_lead, vs_lead, in_win;
  logic [11:0] pix_x, pix_y, vcnt_l, line_total_l, line_active_l, v_active_l;
  logic [31:0] x_off, y_off;

  assign hs_lead = (hs_s1_q == HS_POL) && (hs_s2_q != HS_POL);
  assign vs_lead = (vs_s1_q == VS_POL) && (vs_s2_q != VS_POL);

  // Line-end effects are folded in first so a coincident VS edge sees them.
  always_comb begin
    pix_x         = hs_lead ? 12'd0 : x_q;
    pix_y         = y_q;
    vcnt_l        = vcnt_q;
    line_total_l  = line_total_q;
    line_active_l = line_active_q;
    if (hs_lead) begin
      vcnt_l       = sat_inc(vcnt_q);
      line_total_l = hcnt_q;
      if (x_q != 12'd0) begin
        pix_y         = sat_inc(y_q);
        line_active_l = x_q;
      end
    end
    v_active_l = (pix_x != 12'd0) ? sat_inc(pix_y) : pix_y;
    // Unsigned wrap makes coordinates left of/above the window fail the test.
    x_off  = 32'(pix_x) - WIN_X;
    y_off  = 32'(pix_y) - WIN_Y;
    in_win = de_s1_q && (x_off < WIN_W) && (y_off < WIN_H) && (32'(wr_cnt_q) < Area);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Sync stages reset to the active level so release never fakes an edge.
      hs_s1_q  <= HS_POL;
      hs_s2_q  <= HS_POL;
      vs_s1_q  <= VS_POL;
      vs_s2_q  <= VS_POL;
      de_s1_q  <= 1'b0;
      req_s1_q <= 1'b0;
      rgb_s1_q <= '0;
    end else begin
      hs_s1_q  <= vga_hs;
      hs_s2_q  <= hs_s1_q;
      vs_s1_q  <= vga_vs;
      vs_s2_q  <= vs_s1_q;
      de_s1_q  <= vga_de;
      req_s1_q <= cap_req;
      rgb_s1_q <= {vga_r, vga_g, vga_b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      vcnt_q        <= '0;
      line_total_q  <= '0;
      line_active_q <= '0;
      vs_seen_q     <= 1'b0;
      h_total       <= '0;
      h_active      <= '0;
      v_total       <= '0;
      v_active      <= '0;
      meas_valid    <= 1'b0;
    end else begin
      hcnt_q        <= hs_lead ? 12'd1 : sat_inc(hcnt_q);
      x_q           <= de_s1_q ? sat_inc(pix_x) : pix_x;
      y_q           <= vs_lead ? 12'd0 : pix_y;
      vcnt_q        <= vs_lead ? 12'd0 : vcnt_l;
      line_total_q  <= line_total_l;
      line_active_q <= line_active_l;
      if (vs_lead) begin
        h_total   <= line_total_l;
        h_active  <= line_active_l;
        v_total   <= vcnt_l;
        v_active  <= v_active_l;
        vs_seen_q <= 1'b1;
        // First frame after reset is partial; only the second edge validates.
        if (vs_seen_q) meas_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cap_busy  <= 1'b0;
      cap_done  <= 1'b0;
      cap_words <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_d     <= '0;
      wr_cnt_q  <= '0;
    end else begin
      mem_we   <= 1'b0;
      cap_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_s1_q) begin
            state_q  <= StArm;
            cap_busy <= 1'b1;
          end
        end
        StArm: begin
          if (vs_lead) begin
            state_q  <= StCapt;
            wr_cnt_q <= '0;
          end
        end
        StCapt: begin
          if (vs_lead) begin
            state_q   <= StDone;
            cap_busy  <= 1'b0;
            cap_done  <= 1'b1;
            cap_words <= wr_cnt_q;
          end else if (in_win) begin
            mem_we   <= 1'b1;
            mem_addr <= wr_cnt_q[ADDR_WIDTH-1:0];
            mem_d    <= rgb_s1_q;
            wr_cnt_q <= wr_cnt_q + WordOne;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture_monitor.sv
// Scoreboard bench for vga_capture_monitor. Two instances share one synthetic
// raster (20 clk/line, HS low 2, DE 12; 10 lines/frame, VS low on line 0,
// DE lines 2..7): A captures a window inside the active area, B a window that
// runs off the bottom of it.
module tb_vga_capture_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       vga_hs, vga_vs, vga_de, cap_req;
  logic [3:0] vga_r, vga_g, vga_b;

  logic        cap_busy_a, cap_done_a, mem_we_a, meas_valid_a;
  logic [4:0]  cap_words_a;
  logic [3:0]  mem_addr_a;
  logic [11:0] mem_d_a, h_total_a, h_active_a, v_total_a, v_active_a;
  logic        cap_busy_b, cap_done_b, mem_we_b, meas_valid_b;
  logic [4:0]  cap_words_b;
  logic [3:0]  mem_addr_b;
  logic [11:0] mem_d_b, h_total_b, h_active_b, v_total_b, v_active_b;

  always #5 clk = ~clk;

  vga_capture_monitor #(
    .HS_POL(1'b0), .VS_POL(1'b0), .WIN_X(2), .WIN_Y(1), .WIN_W(4), .WIN_H(3), .ADDR_WIDTH(4)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .cap_req(cap_req),
    .cap_busy(cap_busy_a), .cap_done(cap_done_a), .cap_words(cap_words_a),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_d(mem_d_a),
    .h_total(h_total_a), .h_active(h_active_a), .v_total(v_total_a), .v_active(v_active_a),
    .meas_valid(meas_valid_a)
  );

  vga_capture_monitor #(
    .HS_POL(1'b0), .VS_POL(1'b0), .WIN_X(2), .WIN_Y(4), .WIN_W(4), .WIN_H(4), .ADDR_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .cap_req(cap_req),
    .cap_busy(cap_busy_b), .cap_done(cap_done_b), .cap_words(cap_words_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_d(mem_d_b),
    .h_total(h_total_b), .h_active(h_active_b), .v_total(v_total_b), .v_active(v_active_b),
    .meas_valid(meas_valid_b)
  );

  typedef struct { int addr; int data; int frame; } wr_t;
  typedef struct { int words; int frame; } dn_t;

  wr_t qa[$], qb[$];
  dn_t qda[$], qdb[$];
  int  n_vec = 0, n_err = 0;
  int  frame_no = 0, cur_v = 0, cur_h = 0;
  bit  gen_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected writes: window rows in order, pixel data {x, y, x^y}.
  task automatic push_wr(input bit to_b, input int frame, input int y0, input int count);
    wr_t w;
    int  n = 0;
    for (int yy = y0; yy < y0 + 4 && n < count; yy++) begin
      for (int xx = 2; xx < 6 && n < count; xx++) begin
        w.addr  = (yy - y0) * 4 + (xx - 2);
        w.data  = (xx << 8) | (yy << 4) | (xx ^ yy);
        w.frame = frame;
        if (to_b) qb.push_back(w);
        else qa.push_back(w);
        n++;
      end
    end
  endtask

  task automatic push_cap(input int frame);
    dn_t d;
    push_wr(1'b0, frame, 1, 12);
    push_wr(1'b1, frame, 4, 8);
    d.frame = frame + 1;
    d.words = 12;
    qda.push_back(d);
    d.words = 8;
    qdb.push_back(d);
  endtask

  task automatic wait_at(input int f, input int v);
    bit hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      #2;
      if (frame_no == f && cur_v == v && cur_h == 0) hit = 1'b1;
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_at: frame %0d line %0d not reached (at %0d/%0d)", f, v, frame_no, cur_v);
    end
  endtask

  // Raster generator
  initial begin
    vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    wait (gen_en);
    forever begin
      for (int v = 0; v < 10; v++) begin
        for (int h = 0; h < 20; h++) begin
          logic [3:0] px, py;
          @(negedge clk);
          cur_v  = v;
          cur_h  = h;
          px     = 4'(h - 4);
          py     = 4'(v - 2);
          vga_hs = (h >= 2);
          vga_vs = (v != 0);
          vga_de = (v >= 2 && v <= 7 && h >= 4 && h <= 15);
          vga_r  = vga_de ? px : 4'd0;
          vga_g  = vga_de ? py : 4'd0;
          vga_b  = vga_de ? (px ^ py) : 4'd0;
        end
      end
      frame_no++;
    end
  end

  // Monitor A
  initial begin
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      #1;
      if (mem_we_a) begin
        if (qa.size() == 0) chk("a_unexpected_write", int'(mem_we_a), 0);
        else begin
          w = qa.pop_front();
          chk("a_addr", int'(mem_addr_a), w.addr);
          chk("a_data", int'(mem_d_a), w.data);
          chk("a_write_frame", frame_no, w.frame);
        end
      end
      if (cap_done_a) begin
        if (qda.size() == 0) chk("a_unexpected_done", int'(cap_done_a), 0);
        else begin
          d = qda.pop_front();
          chk("a_cap_words", int'(cap_words_a), d.words);
          chk("a_done_frame", frame_no, d.frame);
        end
      end
    end
  end

  // Monitor B
  initial begin
    wr_t w;
    dn_t d;
    forever begin
      @(negedge clk);
      #1;
      if (mem_we_b) begin
        if (qb.size() == 0) chk("b_unexpected_write", int'(mem_we_b), 0);
        else begin
          w = qb.pop_front();
          chk("b_addr", int'(mem_addr_b), w.addr);
          chk("b_data", int'(mem_d_b), w.data);
          chk("b_write_frame", frame_no, w.frame);
        end
      end
      if (cap_done_b) begin
        if (qdb.size() == 0) chk("b_unexpected_done", int'(cap_done_b), 0);
        else begin
          d = qdb.pop_front();
          chk("b_cap_words", int'(cap_words_b), d.words);
          chk("b_done_frame", frame_no, d.frame);
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_mem_we"}, int'(mem_we_a), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr_a), 0);
    chk({tag, "_mem_d"}, int'(mem_d_a), 0);
    chk({tag, "_cap_busy"}, int'(cap_busy_a), 0);
    chk({tag, "_cap_done"}, int'(cap_done_a), 0);
    chk({tag, "_cap_words"}, int'(cap_words_a), 0);
    chk({tag, "_h_total"}, int'(h_total_a), 0);
    chk({tag, "_v_total"}, int'(v_total_a), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid_a), 0);
    chk({tag, "_b_cap_words"}, int'(cap_words_b), 0);
  endtask

  task automatic chk_meas(input string tag);
    chk({tag, "_meas_valid"}, int'(meas_valid_a), 1);
    chk({tag, "_h_total"}, int'(h_total_a), 20);
    chk({tag, "_h_active"}, int'(h_active_a), 12);
    chk({tag, "_v_total"}, int'(v_total_a), 10);
    chk({tag, "_v_active"}, int'(v_active_a), 6);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    cap_req = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_state("por");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    gen_en = 1'b1;

    // First VS edge only: measurements not yet valid
    wait_at(0, 5);
    chk("f0_meas_valid", int'(meas_valid_a), 0);

    // Second VS edge (coincident with HS edge): full measurement set
    wait_at(1, 5);
    chk_meas("f1");

    // Single-cycle request mid-frame: capture of frame 2, done at frame 3
    cap_req = 1'b1;
    push_cap(2);
    @(negedge clk);
    #2;
    cap_req = 1'b0;
    @(negedge clk);
    #2;
    chk("arm_cap_busy", int'(cap_busy_a), 1);

    // Held request: captures of frames 4 and 6
    wait_at(3, 5);
    chk("f3_cap_busy", int'(cap_busy_a), 0);
    cap_req = 1'b1;
    push_cap(4);
    push_cap(6);
    wait_at(6, 5);
    cap_req = 1'b0;

    // Reset after five writes of capture of frame 8
    wait_at(7, 5);
    chk("f7_cap_busy", int'(cap_busy_a), 0);
    cap_req = 1'b1;
    push_wr(1'b0, 8, 1, 5);
    @(negedge clk);
    #2;
    cap_req = 1'b0;
    n = 0;
    for (int i = 0; i < 1000 && n < 5; i++) begin
      @(negedge clk);
      #2;
      if (mem_we_a) n++;
    end
    chk("writes_before_reset", n, 5);
    reset_n = 1'b0;
    #1;
    chk_reset_state("mid_cap_reset");
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b1;

    // No request since reset: no writes, no done; measurements recover
    wait_at(10, 5);
    chk_meas("f10");
    chk("f10_cap_busy", int'(cap_busy_a), 0);
    chk("f10_cap_words", int'(cap_words_a), 0);
    chk("qa_left", qa.size(), 0);
    chk("qb_left", qb.size(), 0);
    chk("qda_left", qda.size(), 0);
    chk("qdb_left", qdb.size(), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
